serial_addsub_n: RTL

//  Parametrised bit-serial adder: adds two WIDTH-bit operands presented LSB-first, one bit per cycle.

---
 rtl/serial_addsub_n.sv | 124 ++++++++++++
 1 files changed

// File: rtl/serial_addsub_n.sv
// Bit-serial adder: two WIDTH-bit operands arrive LSB first, one bit per cycle, with start/busy/done handshake.
// Define SERIAL_ADDSUB_SUB_EN to add the 'sub' input and a subtract mode (A-B).
module serial_addsub_n #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
`ifdef SERIAL_ADDSUB_SUB_EN
    input  logic             sub,
`endif
    input  logic             a,
    input  logic             b,
    output logic [WIDTH-1:0] sum,
    output logic             busy,
    output logic             done,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] shreg;
    logic             op_sub;
    logic             sub_in;
    logic             accept;
    logic             last_bit;
    logic             b_eff;
    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] result;

`ifdef SERIAL_ADDSUB_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_bit = (state == RUN) && (cnt == LAST);

    // Subtraction is A + ~B + 1: invert B here and preload the carry with 1 at start.
    assign b_eff  = b ^ op_sub;
    assign s_bit  = a ^ b_eff ^ carry;
    assign c_next = (a & b_eff) | (a & carry) | (b_eff & carry);
    assign result = {s_bit, shreg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Counter parks at the last index; accept re-arms it, so nothing carries across operations.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt    <= '0;
            carry  <= 1'b0;
            shreg  <= '0;
            op_sub <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            carry  <= sub_in;
            shreg  <= '0;
            op_sub <= sub_in;
        end else if (state == RUN) begin
            shreg <= result;
            carry <= c_next;
            if (!last_bit) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Overflow is carry into the MSB (still in 'carry' during the last bit) xor carry out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum  <= '0;
            cout <= 1'b0;
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else if (last_bit) begin
            sum  <= result;
            cout <= c_next;
            zero <= (result == '0);
            ovf  <= carry ^ c_next;
        end
    end

endmodule
